// File: rtl/hfifo_arb_pkg.sv
// Shared types and constants for the hfifo_arb controller:
// write/read FSM state encodings, default data width and the
// statistics counter width with its saturation value.
package hfifo_arb_pkg;

  typedef enum logic {
    W_IDLE   = 1'b0,
    W_SETTLE = 1'b1
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_POP  = 2'd1,
    R_CAP  = 2'd2
  } rstate_t;

  localparam int unsigned DW_DEFAULT = 4;

  localparam int unsigned     CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/hfifo_rr_pick.sv
// Combinational round-robin picker. The search starts one past the
// pointer and wraps modulo NREQ; the first requesting port found wins.
// Outputs the winner both one-hot and as an index.
module hfifo_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx
);

  // Scan candidates ptr+1 .. ptr+NREQ, keep the first requester.
  always_comb begin : pick
    int unsigned c;
    logic        found;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    c       = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      c = (32'(ptr) + k) % NREQ;
      if (!found && req[c]) begin
        found     = 1'b1;
        win_oh[c] = 1'b1;
        win_idx   = c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/hfifo_arb.sv
// hfifo_arb: round-robin arbitration of NREQ producers onto the single
// hfifo write port, plus a drain sequencer that pops hfifo into a
// valid/ready output register. All outputs are registered.
// Optional build macro: HFIFO_ARB_STATS_EN enables saturating
// push/pop counters; otherwise push_cnt/pop_cnt are tied to zero.
module hfifo_arb
  import hfifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = DW_DEFAULT
) (
  input  logic               SYSTEM_CLOCK,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               fifo_push,
  output logic [DW-1:0]      fifo_din,
  input  logic               fifo_not_full,
  output logic               fifo_pop,
  input  logic               fifo_rdy,
  input  logic [DW-1:0]      fifo_dout,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  input  logic               out_ready,
  output logic [7:0]         push_cnt,
  output logic [7:0]         pop_cnt
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wstate_t         wstate;
  rstate_t         rstate;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;

  hfifo_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  // Write FSM: grant one producer, then settle a cycle so hfifo status
  // and the granted producer's req can update before the next pick.
  always_ff @(posedge SYSTEM_CLOCK or posedge reset) begin
    if (reset) begin
      wstate    <= W_IDLE;
      gnt       <= '0;
      fifo_push <= 1'b0;
      fifo_din  <= '0;
      ptr       <= IW'(NREQ - 1);
    end else begin
      case (wstate)
        W_IDLE: begin
          if ((|req) && fifo_not_full) begin
            gnt       <= win_oh;
            fifo_push <= 1'b1;
            fifo_din  <= req_data[32'(win_idx)*DW +: DW];
            ptr       <= win_idx;
            wstate    <= W_SETTLE;
          end
        end
        default: begin
          gnt       <= '0;
          fifo_push <= 1'b0;
          wstate    <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: one pop in flight at a time; the popped word is captured
  // two cycles after the pop pulse. A consumer transfer clears out_valid
  // unless R_CAP reloads on the same edge (later assignment wins).
  always_ff @(posedge SYSTEM_CLOCK or posedge reset) begin
    if (reset) begin
      rstate    <= R_IDLE;
      fifo_pop  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      case (rstate)
        R_IDLE: begin
          if (fifo_rdy && (!out_valid || out_ready)) begin
            fifo_pop <= 1'b1;
            rstate   <= R_POP;
          end
        end
        R_POP: begin
          fifo_pop <= 1'b0;
          rstate   <= R_CAP;
        end
        R_CAP: begin
          out_data  <= fifo_dout;
          out_valid <= 1'b1;
          rstate    <= R_IDLE;
        end
        default: begin
          fifo_pop <= 1'b0;
          rstate   <= R_IDLE;
        end
      endcase
    end
  end

`ifdef HFIFO_ARB_STATS_EN
  // Saturating push/pop pulse counters, cleared only by reset.
  always_ff @(posedge SYSTEM_CLOCK or posedge reset) begin
    if (reset) begin
      push_cnt <= '0;
      pop_cnt  <= '0;
    end else begin
      if (fifo_push && (push_cnt != CNT_MAX))
        push_cnt <= push_cnt + 8'd1;
      if (fifo_pop && (pop_cnt != CNT_MAX))
        pop_cnt <= pop_cnt + 8'd1;
    end
  end
`else
  assign push_cnt = '0;
  assign pop_cnt  = '0;
`endif

endmodule

// File: doc/hfifo_arb.md
# hfifo_arb

Shared-access controller for the `hfifo` 4-bit FIFO. It arbitrates up to NREQ producer ports onto the single FIFO write port with round-robin fairness. It also runs a drain sequencer that pops the FIFO into a valid/ready output register. The block sits between the board-level stimulus/LED logic and one `hfifo` instance. It owns all `push`/`pop` traffic to that instance.

## Interface
- NREQ, 4: number of producer ports, 2..8.
- DW, 4: data width; must match the `hfifo` width.
- SYSTEM_CLOCK  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req  in  NREQ  per-producer request. Held high with req_data stable until gnt is seen.
- req_data  in  NREQ*DW  producer data; port i occupies bits [i*DW +: DW].
- gnt  out  NREQ  one-hot, one-cycle acknowledge; the word was pushed.
- fifo_push  out  1  to `hfifo.push`.
- fifo_din  out  DW  to `hfifo.din`.
- fifo_not_full  in  1  from `hfifo.not_full`.
- fifo_pop  out  1  to `hfifo.pop`.
- fifo_rdy  in  1  from `hfifo.rdy` (FIFO non-empty).
- fifo_dout  in  DW  from `hfifo.dout`.
- out_valid  out  1  output register holds a word.
- out_data  out  DW  output word.
- out_ready  in  1  consumer accepts; transfer occurs when out_valid & out_ready.
- push_cnt  out  8  saturating push count; see Configuration.
- pop_cnt  out  8  saturating pop count; see Configuration.

## Operation
- All outputs are registered.
- Reset values:
  - gnt = 0, fifo_push = 0, fifo_din = 0, fifo_pop = 0
  - out_valid = 0, out_data = 0
  - push_cnt = 0, pop_cnt = 0
  - rr pointer = NREQ-1, so port 0 wins first
  - both FSMs idle
- Write FSM, states W_IDLE and W_SETTLE:
  - W_IDLE: if any req and fifo_not_full, pick the winner i. The search starts at pointer+1 and wraps modulo NREQ.
  - On that edge: gnt[i]<=1, fifo_push<=1, fifo_din<=req_data[i], pointer<=i, state<=W_SETTLE.
  - W_SETTLE: gnt<=0, fifo_push<=0, state<=W_IDLE. No arbitration happens in this state.
  - This gives `hfifo` status one cycle to update, and lets the granted producer drop or refresh req.
  - If fifo_not_full=0, no grant is issued. Requests wait with no loss and no error.
- Read FSM, states R_IDLE, R_POP and R_CAP:
  - R_IDLE: if fifo_rdy and (!out_valid or out_ready), then fifo_pop<=1 and go to R_POP.
  - R_POP: fifo_pop<=0, go to R_CAP.
  - R_CAP: out_data<=fifo_dout, out_valid<=1, go to R_IDLE.
  - out_valid clears on any edge with out_valid & out_ready, unless R_CAP loads a new word on that same edge.
- At most one pop is in flight, so the output register never overflows.
- Write and read FSMs are independent. A push and a pop can occur in the same cycle.

## Timing
- Grant latency: req seen in W_IDLE → gnt/fifo_push high on the next cycle.
- Maximum push rate: one word every 2 cycles.
- A single requester that holds req continuously is granted every 2 cycles.
- Round-robin order with req=4'b1111 continuously: 0,1,2,3,0,...
- Pop latency: fifo_rdy in R_IDLE → fifo_pop on the next cycle → out_valid 2 cycles after fifo_pop.
- Drain throughput: one word per 3 cycles with out_ready held high.
- Reset asserted mid-operation: all state clears immediately. Any pending gnt is withdrawn. The shared reset clears `hfifo` as well.

## Configuration
- HFIFO_ARB_STATS_EN defined:
  - push_cnt increments on each fifo_push pulse.
  - pop_cnt increments on each fifo_pop pulse.
  - Both saturate at 8'hFF and clear only on reset.
- HFIFO_ARB_STATS_EN undefined: push_cnt and pop_cnt are constant 0 and no counter logic is built. The ports remain present.

## Structure
- Package `hfifo_arb_pkg` holds:
  - write state encodings W_IDLE=1'b0, W_SETTLE=1'b1
  - read state encodings R_IDLE=2'd0, R_POP=2'd1, R_CAP=2'd2
  - default DW=4
  - counter width 8 and its saturation constant
- Sub-module `hfifo_rr_pick`: combinational round-robin picker. Inputs are req and pointer; outputs are a one-hot winner and an index. It is reused for any future shared-resource port.

## Test plan
- Reset, then req=4'b0001 with data 4'hA, FIFO empty → gnt=4'b0001 one cycle later, fifo_push=1 with fifo_din=4'hA. Then R_POP/R_CAP give out_valid=1 with out_data=4'hA.
- req=4'b1111, data 1/2/3/4, out_ready=1 → grants in order 0,1,2,3, spaced 2 cycles apart. out_data sequence is 1,2,3,4.
- FIFO filled until fifo_not_full=0, req=4'b0010 → no gnt while full. After one pop frees space, gnt[1] is issued and no data is lost.
- out_ready=0 with 3 words queued → exactly one pop, out_valid held, fifo_pop stays 0. On raising out_ready, the remaining 2 words drain.
- reset pulsed in W_SETTLE and R_POP → all outputs return to their reset values. The first grant after release goes to port 0.
- With HFIFO_ARB_STATS_EN defined, 300 pushes → push_cnt=8'hFF. Without the macro, push_cnt stays 0.
